// File: rtl/id_ex_operand_stage.sv
//==============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register with EX/MEM/WB operand forwarding,
//               load-use bubble insertion, back-pressure and flush.
//               Optional macro ID_EX_STALL_CNT_EN adds a saturating stall_cnt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_operand_stage #(
    parameter int DW  = 16,
    parameter int AW  = 3,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_ra,
    input  logic [AW-1:0]  id_rb,
    input  logic           id_use_ra,
    input  logic           id_use_rb,
    input  logic [AW-1:0]  id_rw,
    input  logic           id_we,
    input  logic           id_is_load,
    input  logic           id_use_imm,
    input  logic [DW-1:0]  id_imm,
    input  logic [OPW-1:0] id_alu_op,
    input  logic [DW-1:0]  bus_a,
    input  logic [DW-1:0]  bus_b,
    input  logic [DW-1:0]  ex_result,
    input  logic [AW-1:0]  mem_rw,
    input  logic           mem_we,
    input  logic [DW-1:0]  mem_result,
    input  logic [AW-1:0]  wb_rw,
    input  logic           wb_we,
    input  logic [DW-1:0]  wb_result,
    input  logic           ex_ready,
    input  logic           flush,
`ifdef ID_EX_STALL_CNT_EN
    output logic [15:0]    stall_cnt,
`endif
    output logic           id_ready,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_op_a,
    output logic [DW-1:0]  ex_op_b,
    output logic [DW-1:0]  ex_store_d,
    output logic [AW-1:0]  ex_rw,
    output logic           ex_we,
    output logic           ex_is_load,
    output logic [OPW-1:0] ex_alu_op
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    logic [0:0]     r_state;
    logic           r_valid;
    logic [DW-1:0]  r_op_a;
    logic [DW-1:0]  r_op_b;
    logic [DW-1:0]  r_store_d;
    logic [AW-1:0]  r_rw;
    logic           r_we;
    logic           r_is_load;
    logic [OPW-1:0] r_alu_op;

    logic           w_hazard;
    logic           w_bubble;
    logic [DW-1:0]  w_fwd_a;
    logic [DW-1:0]  w_fwd_b;

    // A load's data is not available until MEM, so a consumer in decode must wait one cycle.
    assign w_hazard = id_valid & r_valid & r_is_load & r_we & (r_rw != '0)
                    & ((id_use_ra & (id_ra == r_rw)) | (id_use_rb & (id_rb == r_rw)));
    assign w_bubble = w_hazard & (r_state == ST_RUN);
    assign id_ready = ex_ready & ~w_hazard & ~flush;

    always_comb begin
        w_fwd_a = bus_a;
        if (id_ra == '0)
            w_fwd_a = '0;
        else if (r_valid & r_we & ~r_is_load & (r_rw == id_ra))
            w_fwd_a = ex_result;
        else if (mem_we & (mem_rw == id_ra))
            w_fwd_a = mem_result;
        else if (wb_we & (wb_rw == id_ra))
            w_fwd_a = wb_result;
    end

    always_comb begin
        w_fwd_b = bus_b;
        if (id_rb == '0)
            w_fwd_b = '0;
        else if (r_valid & r_we & ~r_is_load & (r_rw == id_rb))
            w_fwd_b = ex_result;
        else if (mem_we & (mem_rw == id_rb))
            w_fwd_b = mem_result;
        else if (wb_we & (wb_rw == id_rb))
            w_fwd_b = wb_result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_valid   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_store_d <= '0;
            r_rw      <= '0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
            r_alu_op  <= '0;
        end else if (flush) begin
            r_state   <= ST_RUN;
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
        end else if (ex_ready) begin
            if (w_hazard) begin
                // Data fields keep their old values; only the control is squashed.
                r_state   <= w_bubble ? ST_BUBBLE : ST_RUN;
                r_valid   <= 1'b0;
                r_we      <= 1'b0;
                r_is_load <= 1'b0;
            end else begin
                r_state   <= ST_RUN;
                r_valid   <= id_valid;
                r_op_a    <= w_fwd_a;
                r_op_b    <= id_use_imm ? id_imm : w_fwd_b;
                r_store_d <= w_fwd_b;
                r_rw      <= id_rw;
                r_we      <= id_valid & id_we;
                r_is_load <= id_valid & id_is_load;
                r_alu_op  <= id_alu_op;
            end
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_hazard & ex_ready & ~flush & (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign ex_valid   = r_valid;
    assign ex_op_a    = r_op_a;
    assign ex_op_b    = r_op_b;
    assign ex_store_d = r_store_d;
    assign ex_rw      = r_rw;
    assign ex_we      = r_we;
    assign ex_is_load = r_is_load;
    assign ex_alu_op  = r_alu_op;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
//==============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Scoreboard bench for id_ex_operand_stage with a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        rst_n;
        logic        id_valid;
        logic [2:0]  id_ra;
        logic [2:0]  id_rb;
        logic        id_use_ra;
        logic        id_use_rb;
        logic [2:0]  id_rw;
        logic        id_we;
        logic        id_is_load;
        logic        id_use_imm;
        logic [15:0] id_imm;
        logic [3:0]  id_alu_op;
        logic [15:0] bus_a;
        logic [15:0] bus_b;
        logic [15:0] ex_result;
        logic [2:0]  mem_rw;
        logic        mem_we;
        logic [15:0] mem_result;
        logic [2:0]  wb_rw;
        logic        wb_we;
        logic [15:0] wb_result;
        logic        ex_ready;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        load;
        logic [2:0]  rw;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sd;
        logic [15:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_use_ra, id_use_rb, id_we, id_is_load, id_use_imm;
    logic [2:0]  id_ra, id_rb, id_rw, mem_rw, wb_rw;
    logic [15:0] id_imm, bus_a, bus_b, ex_result, mem_result, wb_result;
    logic [3:0]  id_alu_op;
    logic        mem_we, wb_we, ex_ready, flush;
    logic        id_ready, ex_valid, ex_we, ex_is_load;
    logic [15:0] ex_op_a, ex_op_b, ex_store_d;
    logic [2:0]  ex_rw;
    logic [3:0]  ex_alu_op;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t m;
    bit   m_known = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DW(16), .AW(3), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rw(id_rw), .id_we(id_we),
        .id_is_load(id_is_load), .id_use_imm(id_use_imm), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .bus_a(bus_a), .bus_b(bus_b), .ex_result(ex_result),
        .mem_rw(mem_rw), .mem_we(mem_we), .mem_result(mem_result), .wb_rw(wb_rw),
        .wb_we(wb_we), .wb_result(wb_result), .ex_ready(ex_ready), .flush(flush),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_d(ex_store_d), .ex_rw(ex_rw), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_alu_op(ex_alu_op)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest producer wins: EX (non-load) before MEM before WB before the register file.
    function automatic logic [15:0] fwd(input logic [2:0] src, input logic [15:0] bus, input stim_t s);
        logic        hit [3];
        logic [15:0] val [3];
        if (src == 3'd0) return 16'h0000;
        hit[0] = m.valid && m.we && !m.load && (m.rw == src); val[0] = s.ex_result;
        hit[1] = s.mem_we && (s.mem_rw == src);               val[1] = s.mem_result;
        hit[2] = s.wb_we && (s.wb_rw == src);                 val[2] = s.wb_result;
        for (int k = 0; k < 3; k++)
            if (hit[k]) return val[k];
        return bus;
    endfunction

    function automatic stim_t quiet();
        stim_t s = '0;
        s.rst_n    = 1'b1;
        s.ex_ready = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bit   hz;
        bit   rdy;
        exp_t n;
        @(posedge clk);
        #2;
        rst_n = s.rst_n; id_valid = s.id_valid; id_ra = s.id_ra; id_rb = s.id_rb;
        id_use_ra = s.id_use_ra; id_use_rb = s.id_use_rb; id_rw = s.id_rw; id_we = s.id_we;
        id_is_load = s.id_is_load; id_use_imm = s.id_use_imm; id_imm = s.id_imm;
        id_alu_op = s.id_alu_op; bus_a = s.bus_a; bus_b = s.bus_b; ex_result = s.ex_result;
        mem_rw = s.mem_rw; mem_we = s.mem_we; mem_result = s.mem_result; wb_rw = s.wb_rw;
        wb_we = s.wb_we; wb_result = s.wb_result; ex_ready = s.ex_ready; flush = s.flush;
        #1;
        hz  = s.id_valid && m.valid && m.load && m.we && (m.rw != 3'd0)
            && ((s.id_use_ra && s.id_ra == m.rw) || (s.id_use_rb && s.id_rb == m.rw));
        rdy = s.ex_ready && !hz && !s.flush;
        if (m_known) chk("id_ready", {15'd0, id_ready}, {15'd0, rdy});
        n = m;
        if (!s.rst_n) begin
            n = '0;
        end else if (s.flush) begin
            n.valid = 0; n.we = 0; n.load = 0;
        end else if (s.ex_ready) begin
            if (hz) begin
                n.valid = 0; n.we = 0; n.load = 0;
                if (n.stall != 16'hFFFF) n.stall = n.stall + 16'd1;
            end else begin
                n.valid = s.id_valid;
                n.we    = s.id_valid && s.id_we;
                n.load  = s.id_valid && s.id_is_load;
                n.rw    = s.id_rw;
                n.op    = s.id_alu_op;
                n.a     = fwd(s.id_ra, s.bus_a, s);
                n.sd    = fwd(s.id_rb, s.bus_b, s);
                n.b     = s.id_use_imm ? s.id_imm : n.sd;
            end
        end
        if (!s.rst_n) m_known = 1;
        if (m_known) q.push_back(n);
        m = n;
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", {15'd0, ex_valid}, {15'd0, e.valid});
                chk("ex_we", {15'd0, ex_we}, {15'd0, e.we});
                chk("ex_is_load", {15'd0, ex_is_load}, {15'd0, e.load});
                if (e.valid) begin
                    chk("ex_rw", {13'd0, ex_rw}, {13'd0, e.rw});
                    chk("ex_alu_op", {12'd0, ex_alu_op}, {12'd0, e.op});
                    chk("ex_op_a", ex_op_a, e.a);
                    chk("ex_op_b", ex_op_b, e.b);
                    chk("ex_store_d", ex_store_d, e.sd);
                end
                if (!e.valid && !e.we && e.a == 16'h0 && e.rw == 3'd0 && e.op == 4'd0
                    && e.b == 16'h0 && e.sd == 16'h0 && e.stall == 16'h0) begin
                    chk("reset_op_a", ex_op_a, 16'h0);
                    chk("reset_op_b", ex_op_b, 16'h0);
                    chk("reset_store_d", ex_store_d, 16'h0);
                end
`ifdef ID_EX_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, e.stall);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        // Reset with toggling inputs.
        for (int i = 0; i < 2; i++) begin
            s = stim_t'({$urandom, $urandom, $urandom, $urandom});
            s.rst_n = 1'b0;
            apply(s);
        end
        // ADD R3, then consumer of R3 with stale bus data.
        s = quiet(); s.id_valid = 1; s.id_rw = 3; s.id_we = 1; s.id_alu_op = 4'h1; apply(s);
        s = quiet(); s.id_valid = 1; s.id_ra = 3; s.id_use_ra = 1; s.ex_result = 16'h0005;
        s.id_rw = 4; s.id_we = 1; apply(s);
        // Priority EX > MEM > WB on R4.
        s = quiet(); s.id_valid = 1; s.id_rb = 4; s.id_use_rb = 1; s.ex_result = 16'h0011;
        s.mem_rw = 4; s.mem_we = 1; s.mem_result = 16'h0022;
        s.wb_rw = 4; s.wb_we = 1; s.wb_result = 16'h0033; s.id_rw = 1; apply(s);
        s.ex_result = 16'h0044; apply(s);
        // Load-use on R5: one bubble, then MEM forward.
        s = quiet(); s.id_valid = 1; s.id_rw = 5; s.id_we = 1; s.id_is_load = 1; apply(s);
        s = quiet(); s.id_valid = 1; s.id_ra = 5; s.id_use_ra = 1; s.bus_a = 16'h1234; apply(s);
        s.mem_rw = 5; s.mem_we = 1; s.mem_result = 16'h00AB; apply(s);
        // R0 is never forwarded and never stalls.
        s = quiet(); s.id_valid = 1; s.id_rw = 0; s.id_we = 1; apply(s);
        s = quiet(); s.id_valid = 1; s.id_ra = 0; s.id_use_ra = 1; s.ex_result = 16'hFFFF;
        s.bus_a = 16'h7777; s.id_rw = 0; s.id_we = 1; s.id_is_load = 1; apply(s);
        s = quiet(); s.id_valid = 1; s.id_ra = 0; s.id_use_ra = 1; s.id_use_imm = 1;
        s.id_imm = 16'h8001; s.bus_b = 16'h4444; s.id_rb = 6; apply(s);
        // Flush while a hazard is pending and EX is stalled.
        s = quiet(); s.id_valid = 1; s.id_rw = 2; s.id_we = 1; s.id_is_load = 1; apply(s);
        s = quiet(); s.id_valid = 1; s.id_ra = 2; s.id_use_ra = 1; s.ex_ready = 0; s.flush = 1; apply(s);
        s.flush = 0; s.ex_ready = 0; apply(s);
        // Randomized traffic on a small register window to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            s = stim_t'({$urandom, $urandom, $urandom, $urandom});
            s.rst_n    = ($urandom_range(0, 199) != 0);
            s.id_valid = ($urandom_range(0, 9) < 8);
            s.id_ra    = 3'($urandom_range(0, 3));
            s.id_rb    = 3'($urandom_range(0, 3));
            s.id_rw    = 3'($urandom_range(0, 3));
            s.mem_rw   = 3'($urandom_range(0, 3));
            s.wb_rw    = 3'($urandom_range(0, 3));
            s.ex_ready = ($urandom_range(0, 9) < 8);
            s.flush    = ($urandom_range(0, 19) == 0);
            apply(s);
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
